// File: rtl/clock_pkg.sv
// clock_pkg: shared FSM state codes, edit_sel encodings and BCD limits for the MM:SS clock path
package clock_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN     = 2'd0;
    localparam state_t ST_SET_MIN = 2'd1;
    localparam state_t ST_SET_SEC = 2'd2;
    localparam state_t ST_COMMIT  = 2'd3;

    localparam logic [1:0] SEL_RUN = 2'b00;
    localparam logic [1:0] SEL_MIN = 2'b01;
    localparam logic [1:0] SEL_SEC = 2'b10;

    localparam logic [3:0] TENS_MAX  = 4'd5;
    localparam logic [3:0] UNITS_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

    // Adds one to a 00..59 pair; any out-of-range tens with a carry folds back to 00
    function automatic bcd_pair_t bcd_inc(input bcd_pair_t p);
        bcd_pair_t r;
        r = p;
        if (p.units >= UNITS_MAX) begin
            r.units = 4'd0;
            r.tens  = (p.tens >= TENS_MAX) ? 4'd0 : p.tens + 4'd1;
        end else begin
            r.units = p.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises one active-low key, debounces it and emits a one-cycle press pulse
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n_i,
    output logic level_n_o,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic sync1_q, sync2_q;
    logic level_q, level_d;
    logic dly_q;
    logic press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic flip;

    // Count consecutive samples disagreeing with the accepted level; the last one flips it
    always_comb begin
        flip    = (sync2_q != level_q) && (cnt_q == LAST);
        cnt_d   = ((sync2_q == level_q) || flip) ? '0 : cnt_q + 1'b1;
        level_d = flip ? sync2_q : level_q;
        press_d = dly_q && !level_q;
    end

    // Synchroniser, accepted level and registered 1->0 pulse; keys read as released out of reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            dly_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            dly_q   <= level_q;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign level_n_o = level_q;
    assign press_o   = press_q;

endmodule

// File: rtl/key_time_setter.sv
// key_time_setter: key front end and set-mode FSM that edits MM:SS and loads it into the running counter
module key_time_setter
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 12_500_000,
    parameter int unsigned BLINK_CYCLES    = 12_500_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] KEY,
    input  logic [3:0] cur_phut0,
    input  logic [3:0] cur_phut,
    input  logic [3:0] cur_giay0,
    input  logic [3:0] cur_giay,
    output logic       run_en,
    output logic       load,
    output logic [3:0] set_phut0,
    output logic [3:0] set_phut,
    output logic [3:0] set_giay0,
    output logic [3:0] set_giay,
    output logic [1:0] edit_sel,
    output logic       blink
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES + REPEAT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);
    localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic mode_ev, inc_ev, inc_lvl_n, mode_lvl_unused;
    state_t state_q, state_d;
    bcd_pair_t min_q, min_d, sec_q, sec_d;
    logic [HW-1:0] hc_q, hc_d;
    logic hold_act_q, hold_act_d, rep_q, rep_d;
    logic [BW-1:0] bc_q, bc_d;
    logic blink_q, blink_d;
    logic edit, stay, inc_take, hold_ok, fire, bump;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clock    (clock),
        .reset_n  (reset_n),
        .key_n_i  (KEY[0]),
        .level_n_o(mode_lvl_unused),
        .press_o  (mode_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clock    (clock),
        .reset_n  (reset_n),
        .key_n_i  (KEY[1]),
        .level_n_o(inc_lvl_n),
        .press_o  (inc_ev)
    );

    // Next state, and the inc hold timer: first repeat after HOLD_CYCLES, then every REPEAT_CYCLES
    always_comb begin
        edit    = (state_q == ST_SET_MIN) || (state_q == ST_SET_SEC);
        state_d = (state_q == ST_COMMIT) ? ST_RUN :
                  !mode_ev               ? state_q :
                  (state_q == ST_RUN)    ? ST_SET_MIN :
                  (state_q == ST_SET_MIN) ? ST_SET_SEC : ST_COMMIT;
        stay       = edit && (state_d == state_q);
        inc_take   = stay && inc_ev;
        hold_ok    = stay && !inc_lvl_n;
        fire       = hold_ok && hold_act_q && !inc_take && (hc_q == (rep_q ? REPEAT_LAST : HOLD_LAST));
        hold_act_d = hold_ok && (inc_take || hold_act_q);
        rep_d      = hold_ok && !inc_take && (fire || rep_q);
        hc_d       = (hold_ok && hold_act_q && !inc_take && !fire) ? hc_q + 1'b1 : '0;
        bump       = inc_take || fire;
    end

    // Edited digits: seeded from the running time on entry, bumped by the pair being edited
    always_comb begin
        min_d = (state_q == ST_RUN && mode_ev) ? bcd_pair_t'({cur_phut0, cur_phut}) :
                (bump && state_q == ST_SET_MIN) ? bcd_inc(min_q) : min_q;
        sec_d = (state_q == ST_RUN && mode_ev) ? bcd_pair_t'({cur_giay0, cur_giay}) :
                (bump && state_q == ST_SET_SEC) ? bcd_inc(sec_q) : sec_q;
    end

    // Blink timer restarts from zero on every edit-state entry and idles outside edit states
    always_comb begin
        bc_d    = (stay && bc_q != BLINK_LAST) ? bc_q + 1'b1 : '0;
        blink_d = stay && (blink_q ^ (bc_q == BLINK_LAST));
    end

    // State, edited digits and timers; reset drops any edit in progress without a load
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            min_q      <= '0;
            sec_q      <= '0;
            hc_q       <= '0;
            hold_act_q <= 1'b0;
            rep_q      <= 1'b0;
            bc_q       <= '0;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            hc_q       <= hc_d;
            hold_act_q <= hold_act_d;
            rep_q      <= rep_d;
            bc_q       <= bc_d;
            blink_q    <= blink_d;
        end
    end

    assign run_en    = (state_q == ST_RUN);
    assign load      = (state_q == ST_COMMIT);
    assign edit_sel  = (state_q == ST_SET_MIN) ? SEL_MIN : (state_q == ST_SET_SEC) ? SEL_SEC : SEL_RUN;
    assign set_phut0 = min_q.tens;
    assign set_phut  = min_q.units;
    assign set_giay0 = sec_q.tens;
    assign set_giay  = sec_q.units;
    assign blink     = blink_q;

endmodule

// File: tb/tb_key_time_setter.sv
// tb_key_time_setter: directed table, corner sequences and randomized run against a reference model
module tb_key_time_setter;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 5;
    localparam int B = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic [1:0] KEY = 2'b11;
    logic [3:0] cur_phut0 = 4'd0, cur_phut = 4'd0, cur_giay0 = 4'd0, cur_giay = 4'd0;
    logic run_en, load, blink;
    logic [3:0] set_phut0, set_phut, set_giay0, set_giay;
    logic [1:0] edit_sel;
    logic [15:0] set_w;

    int tests = 0;
    int fails = 0;
    bit mdl_on = 0;
    bit load_seen = 0;

    logic hist [2][64];
    logic ah [2][3];
    int nidx, st, mm, ss, held, age;

    key_time_setter #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .BLINK_CYCLES(B)
    ) dut (
        .clock(clock), .reset_n(reset_n), .KEY(KEY),
        .cur_phut0(cur_phut0), .cur_phut(cur_phut), .cur_giay0(cur_giay0), .cur_giay(cur_giay),
        .run_en(run_en), .load(load),
        .set_phut0(set_phut0), .set_phut(set_phut), .set_giay0(set_giay0), .set_giay(set_giay),
        .edit_sel(edit_sel), .blink(blink)
    );

    assign set_w = {set_phut0, set_phut, set_giay0, set_giay};

    always #5 clock = ~clock;

    always @(negedge clock) if (load) load_seen = 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 64; j++) hist[i][j] = 1'b1;
            for (int j = 0; j < 3; j++) ah[i][j] = 1'b1;
        end
        nidx = 64;
        st = 0; mm = 0; ss = 0; held = -1; age = 0;
    endtask

    // Key level accepted once the last D synchronised samples all show the other level
    task automatic model_edge(input logic [1:0] k, input logic [15:0] c);
        logic ev [2];
        logic inc_dn, flip;
        int nst;
        bit inc_ok, rep;
        nidx++;
        inc_dn = !ah[1][0];
        for (int i = 0; i < 2; i++) begin
            hist[i][nidx & 63] = k[i];
            ev[i] = ah[i][2] && !ah[i][1];
            flip = 1'b1;
            for (int j = 2; j < D + 2; j++) if (hist[i][(nidx - j) & 63] == ah[i][0]) flip = 1'b0;
            ah[i][2] = ah[i][1];
            ah[i][1] = ah[i][0];
            if (flip) ah[i][0] = !ah[i][0];
        end
        nst = (st == 3) ? 0 : ev[0] ? st + 1 : st;
        inc_ok = (st == 1 || st == 2) && ev[1] && !ev[0];
        rep = 0;
        if ((st == 1 || st == 2) && nst == st && inc_dn) begin
            if (inc_ok) held = 0;
            else if (held >= 0) begin
                held++;
                rep = (held >= H) && ((held - H) % R == 0);
            end
        end else held = -1;
        if (st == 0 && ev[0]) begin
            mm = int'(c[15:12]) * 10 + int'(c[11:8]);
            ss = int'(c[7:4]) * 10 + int'(c[3:0]);
        end
        if (inc_ok || rep) begin
            if (st == 1) mm = (mm + 1) % 60;
            else ss = (ss + 1) % 60;
        end
        if ((nst == 1 || nst == 2) && nst == st) age++;
        else age = 0;
        st = nst;
    endtask

    function automatic logic [20:0] model_out();
        logic [1:0] sel;
        sel = (st == 1) ? 2'd1 : (st == 2) ? 2'd2 : 2'd0;
        return {st == 0, st == 3, sel, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                (st == 1 || st == 2) && ((age / B) % 2 == 1)};
    endfunction

    task automatic step();
        logic [1:0] k;
        logic [15:0] c;
        k = KEY;
        c = {cur_phut0, cur_phut, cur_giay0, cur_giay};
        @(posedge clock);
        if (reset_n) model_edge(k, c);
        #1;
        if (mdl_on) check("model", {run_en, load, edit_sel, set_w, blink}, model_out());
    endtask

    task automatic press(input logic [1:0] k, input int hold);
        KEY = k;
        repeat (hold) step();
        KEY = 2'b11;
        repeat (14) step();
    endtask

    task automatic do_reset();
        KEY = 2'b11;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  key;
        int          hold;
        logic [15:0] cur;
        logic [1:0]  sel;
        logic [15:0] set;
        logic        run;
    } vec_t;

    vec_t tv [18];

    initial begin
        int n, loads, after, prev;
        int chg [$];
        int exp_off [4];
        tv[0]  = '{2'b11,  3, 16'h1234, 2'b00, 16'h0000, 1'b1};
        tv[1]  = '{2'b10,  3, 16'h1234, 2'b00, 16'h0000, 1'b1};
        tv[2]  = '{2'b10, 10, 16'h1234, 2'b01, 16'h1234, 1'b0};
        tv[3]  = '{2'b01, 10, 16'h1234, 2'b01, 16'h1334, 1'b0};
        tv[4]  = '{2'b10, 10, 16'h1234, 2'b10, 16'h1334, 1'b0};
        tv[5]  = '{2'b01, 10, 16'h1234, 2'b10, 16'h1335, 1'b0};
        tv[6]  = '{2'b10, 10, 16'h1234, 2'b00, 16'h1335, 1'b1};
        tv[7]  = '{2'b01, 10, 16'h1234, 2'b00, 16'h1335, 1'b1};
        tv[8]  = '{2'b10, 10, 16'h5809, 2'b01, 16'h5809, 1'b0};
        tv[9]  = '{2'b01, 10, 16'h5809, 2'b01, 16'h5909, 1'b0};
        tv[10] = '{2'b01, 10, 16'h5809, 2'b01, 16'h0009, 1'b0};
        tv[11] = '{2'b10, 10, 16'h5809, 2'b10, 16'h0009, 1'b0};
        tv[12] = '{2'b01, 10, 16'h5809, 2'b10, 16'h0010, 1'b0};
        tv[13] = '{2'b10, 10, 16'h5809, 2'b00, 16'h0010, 1'b1};
        tv[14] = '{2'b10, 10, 16'h7909, 2'b01, 16'h7909, 1'b0};
        tv[15] = '{2'b01, 10, 16'h7909, 2'b01, 16'h0009, 1'b0};
        tv[16] = '{2'b00, 10, 16'h7909, 2'b10, 16'h0009, 1'b0};
        tv[17] = '{2'b10, 10, 16'h7909, 2'b00, 16'h0009, 1'b1};
        exp_off = '{20, 25, 30, 35};

        // reset values while held and after release
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_hold", {run_en, load, edit_sel, set_w, blink}, {1'b1, 1'b0, 2'b00, 16'h0, 1'b0});
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        step();
        check("reset_after", {run_en, load, edit_sel, set_w, blink}, {1'b1, 1'b0, 2'b00, 16'h0, 1'b0});

        // directed table
        for (int i = 0; i < 18; i++) begin
            {cur_phut0, cur_phut, cur_giay0, cur_giay} = tv[i].cur;
            press(tv[i].key, tv[i].hold);
            check($sformatf("vec%0d_sel", i), edit_sel, tv[i].sel);
            check($sformatf("vec%0d_set", i), set_w, tv[i].set);
            check($sformatf("vec%0d_run", i), run_en, tv[i].run);
        end

        // mode edge to edit_sel=01: 7 edges after the first edge that samples it
        {cur_phut0, cur_phut, cur_giay0, cur_giay} = 16'h1234;
        KEY = 2'b10;
        n = 0;
        while (edit_sel != 2'b01 && n < 20) begin
            step();
            n++;
        end
        check("latency_edges", n, 8);
        check("latency_set", set_w, 16'h1234);
        KEY = 2'b11;
        repeat (14) step();
        press(2'b10, 10);
        check("commit_pre_sel", edit_sel, 2'b10);

        // commit: single load cycle, digits stable, then RUN
        KEY = 2'b10;
        loads = 0;
        after = 0;
        for (int j = 0; j < 20; j++) begin
            if (j == 10) KEY = 2'b11;
            step();
            if (load) begin
                loads++;
                after = 1;
                check("commit_set", set_w, 16'h1234);
                check("commit_run", run_en, 1'b0);
            end else if (after == 1) begin
                after = 2;
                check("commit_post", {run_en, edit_sel}, {1'b1, 2'b00});
            end
        end
        check("commit_loads", loads, 1);

        // auto-repeat in SET_SEC starting from 00
        {cur_phut0, cur_phut, cur_giay0, cur_giay} = 16'h0000;
        press(2'b10, 10);
        press(2'b10, 10);
        check("repeat_pre", {edit_sel, set_w}, {2'b10, 16'h0000});
        KEY = 2'b01;
        n = 0;
        while (set_giay != 4'd1 && n < 20) begin
            step();
            n++;
        end
        check("repeat_first", set_giay, 4'd1);
        prev = int'(set_giay);
        for (int off = 1; off <= 50; off++) begin
            if (off == 32) KEY = 2'b11;
            step();
            if (int'(set_giay) != prev) chg.push_back(off);
            prev = int'(set_giay);
        end
        check("repeat_count", chg.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("repeat_off%0d", k), (k < chg.size()) ? chg[k] : -1, exp_off[k]);
        check("repeat_final", set_w, 16'h0005);

        // reset while editing seconds
        check("midreset_pre", edit_sel, 2'b10);
        load_seen = 0;
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        check("midreset_now", {run_en, load, edit_sel, set_w}, {1'b1, 1'b0, 2'b00, 16'h0});
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (10) step();
        check("midreset_noload", load_seen, 1'b0);
        check("midreset_sel", edit_sel, 2'b00);

        // randomized run against the reference model
        do_reset();
        mdl_on = 1;
        for (int it = 0; it < 300; it++) begin
            int pick;
            if ($urandom_range(0, 4) == 0) begin
                cur_phut0 = 4'($urandom_range(0, 5));
                cur_phut  = 4'($urandom_range(0, 9));
                cur_giay0 = 4'($urandom_range(0, 5));
                cur_giay  = 4'($urandom_range(0, 9));
            end
            pick = int'($urandom_range(0, 5));
            KEY = (pick < 3) ? 2'b11 : 2'(pick - 3);
            repeat (($urandom_range(0, 9) < 7) ? $urandom_range(1, 12) : $urandom_range(20, 45)) step();
        end
        KEY = 2'b11;
        repeat (20) step();
        mdl_on = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
